// File: rtl/mlp_pkg.sv
// Shared MLP definitions: backward-pass FSM states, address-width helper and
// the signed saturation function also used by the forward neuron.
package mlp_pkg;

  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

  localparam int SAT_W = 64;

  // Index width, never below one bit so a single-weight neuron still has an address.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_to(input logic signed [SAT_W-1:0] v,
                                                     input int w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/sat_shift.sv
// Arithmetic right shift (static SHIFT followed by run-time shamt) and
// saturation of the result into an OW-bit signed range.
module sat_shift
  import mlp_pkg::*;
#(
  parameter int IW    = 16,
  parameter int OW    = 8,
  parameter int SHIFT = 0,
  parameter int SW    = 1
) (
  input  logic signed [IW-1:0] din,
  input  logic        [SW-1:0] shamt,
  output logic signed [OW-1:0] dout
);

  logic signed [IW-1:0]    shifted;
  logic signed [SAT_W-1:0] clamped;

  always_comb begin
    shifted = (din >>> SHIFT) >>> shamt;
    clamped = sat_to(SAT_W'(shifted), OW);
    dout    = OW'(clamped);
  end

endmodule

// File: rtl/neuron_backprop.sv
// Backward pass of one neuron: owns the weight registers, updates them one per
// cycle after a start pulse and streams the error for the previous layer.
module neuron_backprop
  import mlp_pkg::*;
#(
  parameter int N   = 2,
  parameter int QM  = 3,
  parameter int QN  = 5,
  parameter int WM  = 6,
  parameter int WN  = 10,
  parameter int LRW = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [addr_w(N)-1:0]       wr_addr,
  input  logic signed [WM+WN-1:0]    wr_data,
  input  logic                       start,
  input  logic signed [QM+QN-1:0]    in [N],
  input  logic signed [QM+QN-1:0]    delta,
  input  logic                       relu_active,
  input  logic [LRW-1:0]             lr_shift,
  output logic signed [WM+WN-1:0]    weights_out [N],
  output logic                       busy,
  output logic                       done,
  output logic                       bp_valid,
  output logic [addr_w(N)-1:0]       bp_idx,
  output logic signed [QM+QN-1:0]    bp_err
);

  localparam int QW  = QM + QN;
  localparam int WW  = WM + WN;
  localparam int AW  = addr_w(N);
  localparam int PW  = 2 * QW;
  localparam int BW  = WW + QW;
  localparam int GSH = 2 * QN - WN;
  localparam int DW  = ((PW > WW) ? PW : WW) + 1;

  if (2 * QN < WN) begin : g_fmt_check
    $error("neuron_backprop: 2*QN must be >= WN");
  end

  state_t               state_reg, state_next;
  logic signed [WW-1:0] w_reg [N];
  logic signed [QW-1:0] in_reg [N];
  logic signed [QW-1:0] delta_reg;
  logic [LRW-1:0]       lr_reg;
  logic [AW-1:0]        k_reg;
  logic signed [QW-1:0] bp_err_reg;
  logic [AW-1:0]        bp_idx_reg;
  logic                 bp_valid_reg;

  logic signed [WW-1:0] w_cur;
  logic signed [QW-1:0] in_cur;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] grad;
  logic signed [BW-1:0] back;
  logic signed [QW-1:0] back_sat;
  logic signed [DW-1:0] diff;
  logic signed [WW-1:0] w_new;

  // delta_reg already holds the ReLU-gated error, so a closed gate zeroes both paths.
  always_comb begin
    w_cur  = w_reg[k_reg];
    in_cur = in_reg[k_reg];
    prod   = PW'(delta_reg) * PW'(in_cur);
    back   = BW'(w_cur) * BW'(delta_reg);
    diff   = DW'(w_cur) - DW'(grad);
    w_new  = WW'(sat_to(SAT_W'(diff), WW));
  end

  sat_shift #(.IW(PW), .OW(PW), .SHIFT(GSH), .SW(LRW)) u_grad_shift (
    .din   (prod),
    .shamt (lr_reg),
    .dout  (grad)
  );

  sat_shift #(.IW(BW), .OW(QW), .SHIFT(WN), .SW(1)) u_err_shift (
    .din   (back),
    .shamt (1'b0),
    .dout  (back_sat)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = UPDATE;
      UPDATE:  if (k_reg == AW'(N - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      k_reg        <= '0;
      delta_reg    <= '0;
      lr_reg       <= '0;
      bp_err_reg   <= '0;
      bp_idx_reg   <= '0;
      bp_valid_reg <= 1'b0;
      for (int i = 0; i < N; i++) begin
        w_reg[i]  <= '0;
        in_reg[i] <= '0;
      end
    end else begin
      state_reg    <= state_next;
      bp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (wr_en) w_reg[wr_addr] <= wr_data;
          if (start) begin
            k_reg     <= '0;
            delta_reg <= relu_active ? delta : '0;
            lr_reg    <= lr_shift;
            for (int i = 0; i < N; i++) in_reg[i] <= in[i];
          end
        end
        UPDATE: begin
          w_reg[k_reg] <= w_new;
          bp_err_reg   <= back_sat;
          bp_idx_reg   <= k_reg;
          bp_valid_reg <= 1'b1;
          k_reg        <= k_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

  for (genvar gi = 0; gi < N; gi++) begin : g_wout
    assign weights_out[gi] = w_reg[gi];
  end

  assign busy     = (state_reg == UPDATE);
  assign done     = (state_reg == DONE);
  assign bp_valid = bp_valid_reg;
  assign bp_idx   = bp_idx_reg;
  assign bp_err   = bp_err_reg;

endmodule

// File: doc/neuron_backprop.md
Name: neuron_backprop

Overview:
- Backward-pass companion to the fully parallel forward neuron. It owns the neuron's N weight registers and drives them in parallel to the forward datapath.
- On a start pulse it serially (one weight per cycle) applies the gradient update w[k] := w[k] - ((delta*in[k]) >>> lr_shift).
- In the same cycles it streams the back-propagated error w_old[k]*delta for the previous layer.
- Sits between the MLP training controller and the forward neuron.

Parameters:
- N, 2, number of inputs/weights.
- QM, 3, integer bits of activations/delta (signed QM.QN).
- QN, 5, fraction bits of activations/delta.
- WM, 6, integer bits of weights (signed WM.WN).
- WN, 10, fraction bits of weights; elaboration error unless 2*QN >= WN.
- LRW, 4, width of lr_shift.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  weight load strobe, honoured only in IDLE.
- wr_addr  in  $clog2(N) (min 1)  weight index to load.
- wr_data  in  WM+WN signed  weight value to load.
- start  in  1  begin update, accepted only in IDLE.
- in  in  [N-1:0] x QM+QN signed  forward activations, sampled at start.
- delta  in  QM+QN signed  error term, sampled at start.
- relu_active  in  1  forward pre-activation was >0; sampled at start.
- lr_shift  in  LRW  learning-rate exponent (rate = 2^-lr_shift), sampled at start.
- weights_out  out  [N-1:0] x WM+WN signed  registered weights to the forward neuron.
- busy  out  1  high in UPDATE.
- done  out  1  one-cycle pulse in DONE.
- bp_valid  out  1  bp_err/bp_idx valid this cycle.
- bp_idx  out  $clog2(N)  index of bp_err.
- bp_err  out  QM+QN signed  back-propagated error for input bp_idx.

Behaviour:
- Reset (rst=1 at an edge):
  - all weights, bp_err, bp_idx, index counter and captured operands := 0.
  - busy=done=bp_valid=0; FSM := IDLE.
  - Reset mid-UPDATE aborts the update; partially updated weights are also cleared.
- FSM states:
  - IDLE: start=1 -> UPDATE with k=0; capture in, delta, lr_shift. The captured gate is eff_delta = relu_active ? delta : 0.
  - UPDATE: one weight per cycle; k increments; from k=N-1 -> DONE.
  - DONE: one cycle, done=1 -> IDLE unconditionally. start in DONE is ignored.
- Loading:
  - wr_en in IDLE writes wr_data to weight[wr_addr] at the edge.
  - wr_en in UPDATE/DONE is ignored.
  - wr_en and start in the same IDLE cycle: the write happens and start is accepted; the update uses the newly written value.
- Timing: start sampled at edge E0. At edge Ek (k=1..N):
  - weight[k-1] is written.
  - bp_err/bp_idx=k-1 are registered with bp_valid=1.
  - bp_valid drops after E(N+1). done is high in the cycle after EN, coinciding with the last bp_valid.
  - Total busy = N cycles.
- Gradient:
  - p = eff_delta*in[k], 2(QM+QN) bits with 2QN fraction bits.
  - g = p >>> (2QN-WN), then >>> lr_shift (arithmetic, floor truncation).
  - w_new = w[k] - g, computed at full width, then saturated to [-2^(WM+WN-1), 2^(WM+WN-1)-1].
- Back error:
  - b = w_old[k]*eff_delta, where w_old is the pre-update value.
  - Arithmetic shift right by WN, then saturate to [-2^(QM+QN-1), 2^(QM+QN-1)-1].
- relu_active=0: weights unchanged; bp_err=0 for all k; the full N-cycle sequence and done still occur.
- weights_out reflects each register immediately after its edge. No combinational path from inputs to outputs.

Decomposition:
- Package mlp_pkg:
  - state enum {IDLE, UPDATE, DONE}.
  - signed saturate-to-width function, shared with the forward neuron.
  - elaboration-check constants.
- One natural sub-module: sat_shift (arithmetic shift + saturate, parameterised in/out widths), instantiated twice (weight path, error path).

Test Plan (default parameters, values are raw integers):
- Basic update:
  - Stimulus: load w0=1024 (1.0), w1=-512; start with in={32,64}, delta=16 (0.5), relu_active=1, lr_shift=1.
  - Response: w0=768, w1=-1024; bp_err stream {16, -8}; done one cycle after the 2nd edge following start.
- Positive saturation:
  - Stimulus: w0=32767, in0=-128, delta=127, lr_shift=0.
  - Response: w0 stays 32767; bp_err0=127 (clamped from 4063).
- Negative saturation:
  - Stimulus: w0=-32768, in0=127, delta=127, lr_shift=0.
  - Response: w0=-32768; bp_err0=-128.
- ReLU gate:
  - Stimulus: the basic-update stimulus with relu_active=0.
  - Response: weights unchanged; bp_err={0,0}; bp_valid 2 cycles; done pulses.
- Protocol:
  - Stimulus: wr_en and start during UPDATE.
  - Response: both ignored. Also check that wr_en+start together in IDLE uses the written weight.
- Reset mid-operation:
  - Stimulus: rst=1 in the cycle after E1.
  - Response: next cycle all weights 0, busy=done=bp_valid=0, state IDLE; a new start then works normally.
